// File: rtl/fpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_sequencer
// Description : Issue/collect stage in front of the fp16 multiply unit.
//               Operand pairs are queued in a small FIFO, presented to the
//               unit with stable operands, and each operation is run as
//               clear -> start -> wait-for-done. The result, condition codes
//               and status flags land in a valid/ready output slot. A
//               watchdog forces a qNaN result if the unit never answers.
// Ports       : clock, reset       - clock, asynchronous active-high reset
//               inValid/inReady    - operand pair handshake (inA, inB)
//               mulIn1/mulIn2      - operands held stable for the unit
//               mulReset/mulStart  - one-cycle clear and start pulses
//               mulDone/mulOut/
//               mulCond/mulFlags   - unit completion level and results
//               outValid/outReady  - result slot handshake
//               outResult/outCond/
//               outFlags/outTimeout- captured result slot contents
//               busy               - an operation is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mul_sequencer #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64,
    parameter int FLAGW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [15:0]      inA,
    input  logic [15:0]      inB,
    output logic [15:0]      mulIn1,
    output logic [15:0]      mulIn2,
    output logic             mulReset,
    output logic             mulStart,
    input  logic             mulDone,
    input  logic [15:0]      mulOut,
    input  logic [3:0]       mulCond,
    input  logic [FLAGW-1:0] mulFlags,
    output logic             outValid,
    input  logic             outReady,
    output logic [15:0]      outResult,
    output logic [3:0]       outCond,
    output logic [FLAGW-1:0] outFlags,
    output logic             outTimeout,
    output logic             busy
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [C_PTR_W:0]   C_FULL_COUNT = (C_PTR_W + 1)'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_WD_LAST    = C_CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]        C_QNAN       = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_START = 2'd2,
        ST_BUSY  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0]        r_fifo_a [DEPTH];
    logic [15:0]        r_fifo_b [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;
    logic [C_CNT_W-1:0] r_wd_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_force;

    // ------------------------------------------------------------------
    // Operand FIFO. A push is gated only by full, so a pop in the same
    // cycle does not open a slot for the incoming pair.
    // ------------------------------------------------------------------
    assign w_full  = (r_count == C_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = inValid && !w_full;
    assign inReady = !w_full;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= inA;
            r_fifo_b[r_wr_ptr] <= inB;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (C_PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (C_PTR_W + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_force      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The slot is free now or is being drained this very cycle.
                if (!w_empty && (!outValid || outReady)) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                w_state_next = ST_START;
            end
            ST_START: begin
                w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                // Done has priority over the watchdog on the final cycle.
                if (mulDone) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_wd_cnt == C_WD_LAST) begin
                    w_force      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mulReset = (r_state == ST_CLR);
    assign mulStart = (r_state == ST_START);
    assign busy     = (r_state != ST_IDLE);

    // Watchdog: cleared while starting, counts every BUSY cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wd_cnt <= r_wd_cnt + C_CNT_W'(1);
        end
    end

    // Operands only move on a pop, so they are steady for the whole op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mulIn1 <= '0;
            mulIn2 <= '0;
        end else if (w_pop) begin
            mulIn1 <= r_fifo_a[r_rd_ptr];
            mulIn2 <= r_fifo_b[r_rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Output slot. Capture only happens in BUSY, which is never entered
    // with the slot still full, so capture and drain cannot collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid   <= 1'b0;
            outResult  <= '0;
            outCond    <= '0;
            outFlags   <= '0;
            outTimeout <= 1'b0;
        end else if (w_capture) begin
            outValid   <= 1'b1;
            outResult  <= mulOut;
            outCond    <= mulCond;
            outFlags   <= mulFlags;
            outTimeout <= 1'b0;
        end else if (w_force) begin
            outValid   <= 1'b1;
            outResult  <= C_QNAN;
            outCond    <= 4'b0000;
            outFlags   <= '0;
            outTimeout <= 1'b1;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mul_sequencer
// Description : Self-checking bench for fpu_mul_sequencer with a behavioural
//               model of the multiply unit (programmable latency, parks in
//               done until cleared) and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_sequencer;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 32;
    localparam int FLAGW   = 5;
    localparam int NEVER   = 1000;

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        int               lat;    // unit done this many cycles after start+1
        logic [15:0]      uout;
        logic [3:0]       ucond;
        logic [FLAGW-1:0] uflags;
    } op_t;

    typedef struct packed {
        logic [15:0]      res;
        logic [3:0]       cond;
        logic [FLAGW-1:0] flags;
        logic             tmo;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             inValid, inReady, mulReset, mulStart, mulDone;
    logic [15:0]      inA, inB, mulIn1, mulIn2, mulOut, outResult;
    logic [3:0]       mulCond, outCond;
    logic [FLAGW-1:0] mulFlags, outFlags;
    logic             outValid, outReady, outTimeout, busy;

    always #5 clock = ~clock;

    fpu_mul_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .FLAGW(FLAGW)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inA(inA), .inB(inB),
        .mulIn1(mulIn1), .mulIn2(mulIn2), .mulReset(mulReset), .mulStart(mulStart),
        .mulDone(mulDone), .mulOut(mulOut), .mulCond(mulCond), .mulFlags(mulFlags),
        .outValid(outValid), .outReady(outReady), .outResult(outResult),
        .outCond(outCond), .outFlags(outFlags), .outTimeout(outTimeout), .busy(busy)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    op_t  u_q[$];
    res_t exp_q[$];
    bit   sb_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the unit answers within the watchdog window iff its
    // done is visible on one of the first TIMEOUT BUSY cycles.
    function automatic res_t model_expect(input op_t o);
        res_t r;
        if (o.lat < TIMEOUT) begin
            r.res = o.uout; r.cond = o.ucond; r.flags = o.uflags; r.tmo = 1'b0;
        end else begin
            r.res = 16'h7E00; r.cond = 4'h0; r.flags = '0; r.tmo = 1'b1;
        end
        return r;
    endfunction

    function automatic op_t mk_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                                  input logic [15:0] o, input logic [3:0] c,
                                  input logic [FLAGW-1:0] f);
        op_t r;
        r.a = a; r.b = b; r.lat = lat; r.uout = o; r.ucond = c; r.uflags = f;
        return r;
    endfunction

    function automatic res_t mk_res(input logic [15:0] o, input logic [3:0] c,
                                    input logic [FLAGW-1:0] f, input logic t);
        res_t r;
        r.res = o; r.cond = c; r.flags = f; r.tmo = t;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Multiply unit model: clear drops done, start loads the next queued
    // op, done rises after the programmed latency and stays high.
    // ------------------------------------------------------------------
    op_t              u_cur;
    logic             u_done = 1'b0;
    int               u_cnt  = -1;
    logic             ovr_en = 1'b0, ovr_done = 1'b0;
    logic [15:0]      ovr_out = '0;
    logic [3:0]       ovr_cond = '0;
    logic [FLAGW-1:0] ovr_flags = '0;

    initial u_cur = mk_op(16'h0, 16'h0, NEVER, 16'h0, 4'h0, '0);

    always @(negedge clock) begin
        if (reset || mulReset) begin
            u_done = 1'b0;
            u_cnt  = -1;
        end else if (mulStart) begin
            if (u_q.size() > 0) u_cur = u_q.pop_front();
            u_cnt  = 0;
            u_done = 1'b0;
        end else if (u_cnt >= 0 && !u_done) begin
            u_cnt++;
            if (u_cnt == u_cur.lat + 1) u_done = 1'b1;
        end
    end

    assign mulDone  = ovr_en ? ovr_done  : u_done;
    assign mulOut   = ovr_en ? ovr_out   : u_cur.uout;
    assign mulCond  = ovr_en ? ovr_cond  : u_cur.ucond;
    assign mulFlags = ovr_en ? ovr_flags : u_cur.uflags;

    // ------------------------------------------------------------------
    // Monitor: protocol invariants every cycle plus the result scoreboard.
    // ------------------------------------------------------------------
    logic [25:0] prev_slot;
    logic [31:0] prev_ops;
    logic        prev_ok = 1'b0, prev_valid, prev_ready, prev_busy, prev_clr;

    always @(negedge clock) begin
        res_t e;
        #2;
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok) begin
                if (prev_valid && !prev_ready)
                    check("slot_stable", {outValid, outResult, outCond, outFlags, outTimeout},
                          {1'b1, prev_slot});
                if (prev_busy && busy)
                    check("operand_stable", {mulIn1, mulIn2}, prev_ops);
                if (mulStart) begin
                    check("start_after_clear", prev_clr, 1'b1);
                    check("operands_to_unit", {mulIn1, mulIn2}, {u_cur.a, u_cur.b});
                end
            end
            if (sb_en && outValid && outReady) begin
                check("result_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("result", {outResult, outCond, outFlags, outTimeout}, e);
                end
            end
            prev_ok    = 1'b1;
            prev_valid = outValid;
            prev_ready = outReady;
            prev_busy  = busy;
            prev_clr   = mulReset;
            prev_slot  = {outResult, outCond, outFlags, outTimeout};
            prev_ops   = {mulIn1, mulIn2};
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic push(input op_t o, input bit to_sb);
        int n;
        n = 0;
        inValid = 1'b1; inA = o.a; inB = o.b;
        while (!inReady && n < 500) begin @(negedge clock); n++; end
        check("push_accept", inReady, 1'b1);
        if (inReady) begin
            u_q.push_back(o);
            if (to_sb) exp_q.push_back(model_expect(o));
        end
        @(negedge clock);
        inValid = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!outValid && n < bound) begin @(negedge clock); n++; end
        check("wait_valid", outValid, 1'b1);
    endtask

    task automatic wait_busy_state(input int bound);
        int n;
        n = 0;
        while (!(busy && !mulReset && !mulStart) && n < bound) begin @(negedge clock); n++; end
        check("reach_busy", busy && !mulReset && !mulStart, 1'b1);
    endtask

    task automatic consume();
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin @(negedge clock); n++; end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t vecs[6];
    op_t  op;
    int   cnt, n;
    bit   flag_a, flag_b, drv_done;

    initial begin
        inValid = 1'b0; inA = '0; inB = '0; outReady = 1'b0;

        vecs[0] = '{mk_op(16'h3C00, 16'h4000, 12, 16'h4000, 4'b0000, 5'b00000),
                    mk_res(16'h4000, 4'b0000, 5'b00000, 1'b0)};
        vecs[1] = '{mk_op(16'hC500, 16'h3800, 0, 16'hC100, 4'b0010, 5'b00001),
                    mk_res(16'hC100, 4'b0010, 5'b00001, 1'b0)};
        vecs[2] = '{mk_op(16'h7000, 16'h7000, TIMEOUT - 1, 16'h7BFF, 4'b0001, 5'b10100),
                    mk_res(16'h7BFF, 4'b0001, 5'b10100, 1'b0)};
        vecs[3] = '{mk_op(16'h1111, 16'h2222, TIMEOUT, 16'h5555, 4'b1111, 5'b11111),
                    mk_res(16'h7E00, 4'b0000, 5'b00000, 1'b1)};
        vecs[4] = '{mk_op(16'h0001, 16'h8001, NEVER, 16'h1234, 4'b0100, 5'b00100),
                    mk_res(16'h7E00, 4'b0000, 5'b00000, 1'b1)};
        vecs[5] = '{mk_op(16'h0000, 16'hFC00, 5, 16'h0000, 4'b1000, 5'b00010),
                    mk_res(16'h0000, 4'b1000, 5'b00010, 1'b0)};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_state",
              {inReady, outValid, mulReset, mulStart, busy, mulIn1, mulIn2,
               outResult, outCond, outFlags, outTimeout}, {1'b1, 62'b0});
        reset = 1'b0;
        @(negedge clock);

        // Single op, cycle by cycle from the push edge t0
        push(mk_op(16'h3C00, 16'h4000, 12, 16'h4000, 4'b0000, 5'b00000), 1'b0);
        check("single_t0", {mulReset, mulStart, outValid}, 3'b000);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check($sformatf("single_t%0d", k), {mulReset, mulStart, outValid},
                  {k == 1, k == 2, k == 16});
        end
        check("single_result", {outResult, outTimeout}, {16'h4000, 1'b0});
        consume();
        check("single_consumed", outValid, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].op, 1'b0);
            wait_valid(200);
            check($sformatf("vec%0d", i), {outResult, outCond, outFlags, outTimeout}, vecs[i].exp);
            consume();
        end

        // Watchdog: count BUSY cycles before the forced result
        push(mk_op(16'h4400, 16'h4400, NEVER, 16'hAAAA, 4'hF, 5'h1F), 1'b0);
        cnt = 0; n = 0;
        while (!outValid && n < 200) begin
            if (busy && !mulReset && !mulStart) cnt++;
            @(negedge clock); n++;
        end
        check("timeout_busy_cycles", cnt, TIMEOUT);
        check("timeout_result", {outValid, outResult, outCond, outFlags, outTimeout, busy},
              {1'b1, 16'h7E00, 4'h0, 5'h00, 1'b1, 1'b0});
        consume();

        // Backpressure: one op dispatched, two queued, fourth stalls
        sb_en = 1'b1;
        push(mk_op(16'h0101, 16'h0202, 2, 16'hA000, 4'b0001, 5'b00001), 1'b1);
        push(mk_op(16'h0303, 16'h0404, 2, 16'hA001, 4'b0010, 5'b00010), 1'b1);
        push(mk_op(16'h0505, 16'h0606, 2, 16'hA002, 4'b0100, 5'b00100), 1'b1);
        fork
            push(mk_op(16'h0707, 16'h0808, 2, 16'hA003, 4'b1000, 5'b01000), 1'b1);
            begin
                repeat (20) @(negedge clock);
                check("bp_stall", {inReady, outValid, outResult, busy},
                      {1'b0, 1'b1, 16'hA000, 1'b0});
                outReady = 1'b1;
            end
        join
        drain("bp_drain", 500);
        flag_a = 1'b0;
        repeat (40) begin @(negedge clock); flag_a |= outValid; end
        check("bp_no_duplicate", flag_a, 1'b0);
        outReady = 1'b0;
        sb_en    = 1'b0;

        // Stale done held through clear/start, real done 5 cycles into BUSY
        ovr_en = 1'b1; ovr_done = 1'b1; ovr_out = 16'h1111; ovr_cond = 4'hF; ovr_flags = 5'h1F;
        push(mk_op(16'hABCD, 16'h1234, NEVER, 16'h0, 4'h0, '0), 1'b0);
        wait_busy_state(20);
        check("stale_ignored", outValid, 1'b0);
        ovr_done = 1'b0; ovr_out = 16'h2222;
        flag_a = 1'b0;
        repeat (5) begin @(negedge clock); flag_a |= outValid; end
        ovr_done = 1'b1; ovr_out = 16'h3333; ovr_cond = 4'b0101; ovr_flags = 5'b01010;
        wait_valid(10);
        check("stale_no_early", flag_a, 1'b0);
        check("stale_result", {outResult, outCond, outFlags, outTimeout},
              {16'h3333, 4'b0101, 5'b01010, 1'b0});
        consume();
        ovr_en = 1'b0; ovr_done = 1'b0;

        // Asynchronous reset mid-BUSY with one pair still queued
        push(mk_op(16'h1357, 16'h2468, NEVER, 16'h0, 4'h0, '0), 1'b0);
        push(mk_op(16'h9999, 16'h8888, NEVER, 16'h0, 4'h0, '0), 1'b0);
        wait_busy_state(20);
        check("pre_reset_operands", {mulIn1, mulIn2}, {16'h1357, 16'h2468});
        #1 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {inReady, outValid, mulReset, mulStart, busy, mulIn1, mulIn2,
               outResult, outCond, outFlags, outTimeout}, {1'b1, 62'b0});
        @(negedge clock);
        reset = 1'b0;
        u_q.delete();
        check("post_reset_ready", inReady, 1'b1);
        outReady = 1'b1;
        flag_a = 1'b0; flag_b = 1'b0;
        repeat (40) begin @(negedge clock); flag_a |= busy; flag_b |= outValid; end
        check("post_reset_idle", {flag_a, flag_b}, 2'b00);
        outReady = 1'b0;

        // Randomized traffic against the reference model
        sb_en = 1'b1; drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    int r;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    op.a = 16'($urandom()); op.b = 16'($urandom());
                    op.uout = 16'($urandom()); op.ucond = 4'($urandom());
                    op.uflags = FLAGW'($urandom());
                    r = $urandom_range(0, 9);
                    if (r < 7)       op.lat = $urandom_range(0, 15);
                    else if (r == 7) op.lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
                    else             op.lat = NEVER;
                    push(op, 1'b1);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge clock);
                    outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        outReady = 1'b1;
        drain("random_drain", 3000);
        outReady = 1'b0;
        sb_en    = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
